// File: rtl/rv32_ic_pkg.sv
// Shared types and constants for the rv32 native-bus interconnect.
package rv32_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } ic_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;
    localparam int unsigned CNT_W             = 16;
    localparam logic [7:0]  ERR_COUNT_MAX     = 8'd255;

endpackage

// File: rtl/rv32_addr_decode.sv
// Combinational base/mask window decoder; the lowest-indexed hitting slave wins.
module rv32_addr_decode
    import rv32_ic_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [31:0]            addr,
    input  logic [N_SLAVES*32-1:0] slave_base,
    input  logic [N_SLAVES*32-1:0] slave_mask,
    output logic                   hit,
    output logic [SEL_W-1:0]       sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!hit && ((addr & slave_mask[32*i +: 32]) == slave_base[32*i +: 32])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rv32_interconnect.sv
// N-slave interconnect for the picorv32 native memory bus with decode-miss error response.
// Define RV32_IC_TIMEOUT_EN to terminate unresponsive slave accesses after TIMEOUT_CYCLES.
module rv32_interconnect
    import rv32_ic_pkg::*;
#(
    parameter int unsigned             N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE     = '0,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK     = '0,
    parameter int unsigned             TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rv32_valid,
    output logic                   rv32_ready,
    input  logic [31:0]            rv32_addr,
    input  logic [3:0]             rv32_wstrb,
    output logic [31:0]            rv32_rdata,
    output logic [N_SLAVES-1:0]    s_valid,
    input  logic [N_SLAVES-1:0]    s_ready,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    output logic                   bus_err,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_count
);

    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    ic_state_e         state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              dec_hit;
    logic [SEL_W-1:0]  dec_sel;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              unused_wstrb;

`ifdef RV32_IC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

    assign unused_wstrb = ^rv32_wstrb;

    rv32_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W)
    ) u_decode (
        .addr       (rv32_addr),
        .slave_base (SLAVE_BASE),
        .slave_mask (SLAVE_MASK),
        .hit        (dec_hit),
        .sel        (dec_sel)
    );

    // Only the selected slave's ready/rdata are visible; others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        s_valid = '0;
        if (state_q == ACCESS) begin
            for (int unsigned i = 0; i < N_SLAVES; i++) begin
                if (sel_q == SEL_W'(i)) s_valid[i] = 1'b1;
            end
        end
    end

    assign rv32_ready = (state_q == RESP);
    assign bus_err    = (state_q == RESP) && err_q;
    assign rv32_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef RV32_IC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rv32_valid) begin
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        err_d   = 1'b0;
`ifdef RV32_IC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef RV32_IC_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error log is committed on the RESP edge; the CPU still holds addr then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_addr  <= '0;
            err_count <= '0;
`ifdef RV32_IC_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef RV32_IC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
            if (state_q == RESP && err_q) begin
                err_addr <= rv32_addr;
                if (err_count != ERR_COUNT_MAX) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
